// File: rtl/rf_pkg.sv
// Shared register-file sizing constants and types for the operand fetch stage.
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy tracking: set by an issuing writer, cleared by write-back,
// and the resulting RAW/WAW hazard flags for the instruction at decode.
module operand_scoreboard #(
  parameter int   NUM_REGS   = rf_pkg::NUM_REGS,
  parameter bit   ZERO_REG0  = 1'b1,
  localparam int  ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  haz_rs1,
  output logic                  haz_rs2,
  output logic                  haz_rd
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // A write-back landing this cycle already resolves the dependency.
  function automatic logic pending(input logic [ADDR_WIDTH-1:0] a);
    return busy_q[a] && !(clr_en && clr_rd == a) && !(ZERO_REG0 && a == '0);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (clr_en && clr_rd == ADDR_WIDTH'(r)) busy_d[r] = 1'b0;
      // Applied after the clear so a new writer wins over a retiring one.
      if (set_en && set_rd == ADDR_WIDTH'(r)) busy_d[r] = 1'b1;
    end
    if (ZERO_REG0) busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy    = busy_q;
  assign haz_rs1 = pending(rs1);
  assign haz_rs2 = pending(rs2);
  assign haz_rd  = pending(rd);

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage between decode and execute: reads operands with write-back
// bypass, tracks in-flight writers, and registers the result toward execute.
module operand_fetch_stage #(
  parameter int  DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int  NUM_REGS   = rf_pkg::NUM_REGS,
  parameter int  CTRL_WIDTH = 8,
  parameter bit  ZERO_REG0  = 1'b1,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  output logic [ADDR_WIDTH-1:0] rf_ra,
  output logic [ADDR_WIDTH-1:0] rf_rb,
  input  logic [DATA_WIDTH-1:0] rf_qa,
  input  logic [DATA_WIDTH-1:0] rf_qb,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_d,
  output logic                  rf_we,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_opa,
  output logic [DATA_WIDTH-1:0] ex_opb,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_rd_we,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [NUM_REGS-1:0]   sb_busy
);

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] ex_opa_q, ex_opa_d;
  logic [DATA_WIDTH-1:0] ex_opb_q, ex_opb_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rd_we_q, ex_rd_we_d;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q, ex_ctrl_d;
  logic                  haz_rs1, haz_rs2, haz_rd;
  logic                  hazard, fire;

  assign rf_ra = id_rs1;
  assign rf_rb = id_rs2;
  assign rf_rd = wb_rd;
  assign rf_d  = wb_data;
  assign rf_we = wb_valid && !(ZERO_REG0 && wb_rd == '0);

  // Hard zero beats bypass, bypass beats the (not yet updated) regfile.
  function automatic logic [DATA_WIDTH-1:0] sel_operand(input logic [ADDR_WIDTH-1:0] rs,
                                                        input logic [DATA_WIDTH-1:0] q);
    if (ZERO_REG0 && rs == '0)      return '0;
    else if (wb_valid && wb_rd == rs) return wb_data;
    else                              return q;
  endfunction

  operand_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (fire && id_rd_we),
    .set_rd  (id_rd),
    .clr_en  (wb_valid),
    .clr_rd  (wb_rd),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .rd      (id_rd),
    .busy    (sb_busy),
    .haz_rs1 (haz_rs1),
    .haz_rs2 (haz_rs2),
    .haz_rd  (haz_rd)
  );

  assign hazard   = haz_rs1 || haz_rs2 || (id_rd_we && haz_rd);
  assign id_ready = !rst && !hazard && (!ex_valid_q || ex_ready);
  assign fire     = id_valid && id_ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_opa_d   = ex_opa_q;
    ex_opb_d   = ex_opb_q;
    ex_rd_d    = ex_rd_q;
    ex_rd_we_d = ex_rd_we_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (fire) begin
      ex_valid_d = 1'b1;
      ex_opa_d   = sel_operand(id_rs1, rf_qa);
      ex_opb_d   = sel_operand(id_rs2, rf_qb);
      ex_rd_d    = id_rd;
      ex_rd_we_d = id_rd_we;
      ex_ctrl_d  = id_ctrl;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_opa_q   <= '0;
      ex_opb_q   <= '0;
      ex_rd_q    <= '0;
      ex_rd_we_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_opa_q   <= ex_opa_d;
      ex_opb_q   <= ex_opb_d;
      ex_rd_q    <= ex_rd_d;
      ex_rd_we_q <= ex_rd_we_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_opa   = ex_opa_q;
  assign ex_opb   = ex_opb_q;
  assign ex_rd    = ex_rd_q;
  assign ex_rd_we = ex_rd_we_q;
  assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: external regfile, behavioural reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_operand_fetch_stage;
  import rf_pkg::*;

  localparam int CW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid, id_ready, id_rd_we;
  reg_addr_t          id_rs1, id_rs2, id_rd;
  logic [CW-1:0]      id_ctrl;
  reg_addr_t          rf_ra, rf_rb, rf_rd;
  reg_data_t          rf_qa, rf_qb, rf_d;
  logic               rf_we;
  logic               wb_valid;
  reg_addr_t          wb_rd;
  reg_data_t          wb_data;
  logic               ex_valid, ex_ready, ex_rd_we;
  reg_data_t          ex_opa, ex_opb;
  reg_addr_t          ex_rd;
  logic [CW-1:0]      ex_ctrl;
  logic [NUM_REGS-1:0] sb_busy;

  operand_fetch_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .CTRL_WIDTH (CW),
    .ZERO_REG0  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .id_rd_we (id_rd_we),
    .id_ctrl  (id_ctrl),
    .rf_ra    (rf_ra),
    .rf_rb    (rf_rb),
    .rf_qa    (rf_qa),
    .rf_qb    (rf_qb),
    .rf_rd    (rf_rd),
    .rf_d     (rf_d),
    .rf_we    (rf_we),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_opa   (ex_opa),
    .ex_opb   (ex_opb),
    .ex_rd    (ex_rd),
    .ex_rd_we (ex_rd_we),
    .ex_ctrl  (ex_ctrl),
    .sb_busy  (sb_busy)
  );

  always #5 clk = ~clk;

  // External regfile: combinational read, write committed on the clock edge.
  reg_data_t regs [NUM_REGS];
  assign rf_qa = regs[rf_ra];
  assign rf_qb = regs[rf_rb];
  always @(posedge clk) if (rf_we) regs[rf_rd] <= rf_d;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: architectural register values, in-flight writers, and
  // the instruction currently presented to execute.
  reg_data_t     arch [NUM_REGS];
  bit            m_busy [NUM_REGS];
  bit            m_valid;
  reg_data_t     m_opa, m_opb;
  reg_addr_t     m_rd;
  bit            m_rd_we;
  logic [CW-1:0] m_ctrl;
  bit            run_cmp;

  function automatic bit m_blocked(input reg_addr_t r);
    return r != 0 && m_busy[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic reg_data_t m_read(input reg_addr_t r);
    if (r == 0) return '0;
    if (wb_valid && wb_rd == r) return wb_data;
    return arch[r];
  endfunction

  always @(negedge clk) begin
    bit                  stall, rdy, fire;
    logic [NUM_REGS-1:0] busy_vec;
    if (run_cmp) begin
      stall = m_blocked(id_rs1) || m_blocked(id_rs2) || (id_rd_we && m_blocked(id_rd));
      rdy   = !rst && !stall && (!m_valid || ex_ready);
      fire  = id_valid && rdy;
      for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = m_busy[r];
      check("id_ready", 64'(id_ready), 64'(rdy));
      check("rf_we",    64'(rf_we),    64'(wb_valid && wb_rd != 0));
      check("ex_valid", 64'(ex_valid), 64'(m_valid));
      check("ex_opa",   64'(ex_opa),   64'(m_opa));
      check("ex_opb",   64'(ex_opb),   64'(m_opb));
      check("ex_rd",    64'(ex_rd),    64'(m_rd));
      check("ex_rd_we", 64'(ex_rd_we), 64'(m_rd_we));
      check("ex_ctrl",  64'(ex_ctrl),  64'(m_ctrl));
      check("sb_busy",  64'(sb_busy),  64'(busy_vec));
      if (rst) begin
        m_valid = 0; m_opa = '0; m_opb = '0; m_rd = '0; m_rd_we = 0; m_ctrl = '0;
        for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
      end else begin
        if (fire) begin
          m_valid = 1;
          m_opa   = m_read(id_rs1);
          m_opb   = m_read(id_rs2);
          m_rd    = id_rd;
          m_rd_we = id_rd_we;
          m_ctrl  = id_ctrl;
        end else if (ex_ready) begin
          m_valid = 0;
        end
        if (wb_valid) m_busy[wb_rd] = 0;
        if (fire && id_rd_we && id_rd != 0) m_busy[id_rd] = 1;
      end
      if (wb_valid && wb_rd != 0) arch[wb_rd] = wb_data;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                       input bit we, input int ctrl);
    id_valid = v;
    id_rs1   = reg_addr_t'(rs1);
    id_rs2   = reg_addr_t'(rs2);
    id_rd    = reg_addr_t'(rd);
    id_rd_we = we;
    id_ctrl  = CW'(ctrl);
  endtask

  task automatic wb(input bit v, input int rd, input reg_data_t d);
    wb_valid = v;
    wb_rd    = reg_addr_t'(rd);
    wb_data  = d;
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs[r] = $urandom;
      arch[r] = regs[r];
      m_busy[r] = 0;
    end
    m_valid = 0; m_opa = '0; m_opb = '0; m_rd = '0; m_rd_we = 0; m_ctrl = '0;
    run_cmp = 1;
    rst = 1; ex_ready = 1;
    issue(1, 1, 2, 3, 1, 8'h5A);
    wb(0, 0, '0);

    // Reset held two cycles with a pending instruction.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_id_ready", 64'(id_ready), 64'd0);
      check("rst_ex_valid", 64'(ex_valid), 64'd0);
      check("rst_sb_busy",  64'(sb_busy),  64'd0);
      adv();
    end
    rst = 0;

    // Plain read after a write-back commit.
    issue(0, 0, 0, 0, 0, 0);
    wb(1, 5, 32'hDEADBEEF);
    adv();
    wb(0, 0, '0);
    issue(1, 5, 0, 1, 0, 8'h01);
    adv();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("read_valid", 64'(ex_valid), 64'd1);
    check("read_opa",   64'(ex_opa),   64'hDEADBEEF);
    check("read_opb",   64'(ex_opb),   64'd0);

    // Same-cycle write-back bypass.
    adv();
    regs[7] = 32'h0BAD0BAD;
    arch[7] = 32'h0BAD0BAD;
    wb(1, 7, 32'h1234);
    issue(1, 7, 0, 0, 0, 8'h02);
    adv();
    wb(0, 0, '0);
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("bypass_opa", 64'(ex_opa), 64'h1234);

    // RAW stall until the writer retires.
    adv();
    issue(1, 0, 0, 3, 1, 8'h03);
    adv();
    issue(1, 0, 3, 0, 0, 8'h04);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("raw_stall", 64'(id_ready),   64'd0);
      check("raw_busy3", 64'(sb_busy[3]), 64'd1);
      adv();
    end
    wb(1, 3, 32'hA5);
    @(negedge clk);
    check("raw_release", 64'(id_ready), 64'd1);
    adv();
    wb(0, 0, '0);
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("raw_opb",   64'(ex_opb),   64'hA5);
    check("raw_clear", 64'(sb_busy),  64'd0);

    // Backpressure: execute stalls for three cycles.
    adv();
    issue(1, 5, 0, 2, 0, 8'h11);
    adv();
    ex_ready = 0;
    issue(1, 7, 0, 2, 0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_id_ready", 64'(id_ready), 64'd0);
      check("bp_ex_ctrl",  64'(ex_ctrl),  64'h11);
      check("bp_ex_opa",   64'(ex_opa),   64'hDEADBEEF);
      adv();
    end
    ex_ready = 1;
    @(negedge clk);
    check("bp_release", 64'(id_ready), 64'd1);
    adv();
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("bp_next_ctrl", 64'(ex_ctrl), 64'h22);
    check("bp_next_opa",  64'(ex_opa),  64'h1234);

    // Register 0: never busy, never written, zero beats bypass.
    adv();
    issue(1, 0, 0, 0, 1, 8'h33);
    wb(1, 0, 32'hFF);
    @(negedge clk);
    check("r0_rf_we", 64'(rf_we), 64'd0);
    adv();
    issue(0, 0, 0, 0, 0, 0);
    wb(0, 0, '0);
    @(negedge clk);
    check("r0_busy", 64'(sb_busy), 64'd0);
    check("r0_opa",  64'(ex_opa),  64'd0);

    // Set wins over a same-cycle clear; the retiring write is bypassed.
    adv();
    issue(1, 0, 0, 4, 1, 8'h44);
    adv();
    wb(1, 4, 32'h77);
    issue(1, 4, 0, 4, 1, 8'h45);
    @(negedge clk);
    check("waw_clear_ready", 64'(id_ready), 64'd1);
    adv();
    wb(0, 0, '0);
    issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("setwin_busy4", 64'(sb_busy[4]), 64'd1);
    check("setwin_opa",   64'(ex_opa),     64'h77);
    adv();
    wb(1, 4, 32'h88);
    adv();
    wb(0, 0, '0);
    @(negedge clk);
    check("clr_busy", 64'(sb_busy), 64'd0);

    // Random traffic over a small register window to force hazards.
    for (int i = 0; i < 3000; i++) begin
      adv();
      rst      = ($urandom_range(0, 99) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 255));
      wb($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom);
    end
    adv();
    @(negedge clk);
    run_cmp = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
